mdu_iterative: RTL and testbench

Parametrised, multi-cycle multiply/divide unit for the MIPS execute stage, the sequential successor to the single-cycle combinational ALU. Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands with a start/busy/done handshake. Writes a 2·WIDTH-bit result into internal HI/LO registers that the pipeline reads via mfhi/mflo. Supports pipeline flush and MIPS-style signed semantics.

---
 rtl/mdu_iterative.sv | 168 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers (one bit per cycle).
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU complete at once with div_by_zero=1.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dz_q, dz_d;

    logic               op_signed, op_div, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] step, prod;
    logic [WIDTH-1:0]   quot, rem;

    assign op_signed = ~op_i[0];
    assign op_div    = op_i[1];
    assign sa        = op_signed & a_i[WIDTH-1];
    assign sb        = op_signed & b_i[WIDTH-1];
    assign abs_a     = sa ? -a_i : a_i;
    assign abs_b     = sb ? -b_i : b_i;

`ifdef MDU_DIV_EN
    logic [WIDTH:0] dtmp, dsub;
`endif

    // Multiply: acc = {partial sum, remaining multiplier}; divide: acc = {remainder, remaining dividend/quotient}
    always_comb begin
        msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        step = {msum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        dtmp = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dsub = dtmp - {1'b0, opnd_q};
        if (is_div_q) begin
            if (dtmp >= {1'b0, opnd_q}) step = {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                        step = {dtmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
`endif
    end

    assign prod = neg_q_q ? -step : step;
    assign quot = neg_q_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    assign rem  = neg_r_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    is_div_d = op_div;
                    neg_q_d  = sa ^ sb;
                    neg_r_d  = sa;
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                    opnd_d   = op_div ? abs_b : abs_a;
`ifdef MDU_DIV_EN
                    if (op_div && b_i == '0) begin
                        state_d = FIN;
                        hi_d    = a_i;
                        lo_d    = '1;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    if (op_div) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`endif
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    // Final iteration result is sign-corrected and written straight into HI/LO
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        if (is_div_q) begin
                            hi_d = rem;
                            lo_d = quot;
                        end else begin
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table plus scoreboard, with flush/reset/busy-start sequences.
// Expectations for DIV/DIVU follow MDU_DIV_EN the same way the design does.
module tb_mdu_iterative;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo),
        .div_by_zero_o(dz)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [W-1:0] a, b, hi, lo; logic dz; } vec_t;
    typedef struct { logic [W-1:0] hi, lo; logic dz; int due; } exp_t;

    exp_t         sb_q[$];
    vec_t         tbl[13];
    int           pass_cnt = 0, total_cnt = 0, cyc = 0, done_cnt = 0, d0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    exp_t         dummy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb_q.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(dz), 64'(e.dz));
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Without the divider, DIV/DIVU leave HI/LO alone and flag div_by_zero
    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        e.hi = v.hi; e.lo = v.lo; e.dz = v.dz; e.due = 0;
`ifndef MDU_DIV_EN
        if (v.op[1]) begin e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; end
`endif
        return e;
    endfunction

    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t v;
        logic [63:0] p;
        int sx, sy;
        v.op = o; v.a = x; v.b = y; v.dz = 1'b0; p = '0;
        sx = $signed(x); sy = $signed(y);
        case (o)
            2'd0: p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
            2'd1: p = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == '0) begin p = {x, 32'hFFFFFFFF}; v.dz = 1'b1; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
                else p = {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == '0) begin p = {x, 32'hFFFFFFFF}; v.dz = 1'b1; end
                else p = {x % y, x / y};
            end
        endcase
        v.hi = p[63:32]; v.lo = p[31:0];
        return v;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input exp_t e, input bit push);
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) begin
            total_cnt++;
            $display("FAIL issue_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        op = o; a = x; b = y; start = 1'b1;
        e.due = cyc + 1 + (e.dz ? 0 : W);
        if (push) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input vec_t v);
        exp_t e = expect_of(v);
        issue(v.op, v.a, v.b, e, 1'b1);
        m_hi = e.hi; m_lo = e.lo;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("drain_queue", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'd3, 32'd88,       32'd0,        32'd88,       32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[5]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[6]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[7]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        tbl[9]  = '{2'd2, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
        tbl[10] = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[11] = '{2'd1, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0};
        tbl[12] = '{2'd2, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        dummy   = '{'0, '0, 1'b0, 0};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz",   64'(dz),   64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run(tbl[i]);
        drain();

        for (int i = 0; i < 10; i++) run(model(2'($urandom_range(0, 3)), $urandom, $urandom));
        drain();

        // A start arriving mid-operation must be ignored
`ifdef MDU_DIV_EN
        run('{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
`else
        run('{2'd1, 32'd100, 32'd7, 32'd0, 32'd700, 1'b0});
`endif
        repeat (9) @(negedge clk);
        op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run('{2'd1, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0});
        drain();

        run('{2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0});
        drain();
        issue(2'd1, 32'd9, 32'd9, dummy, 1'b0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(done_cnt), 64'(d0));
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd12);

        flush = 1'b1; start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_start_no_done", 64'(done_cnt), 64'(d0));
        check("flush_start_lo", 64'(lo), 64'd12);

        run('{2'd1, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 1'b0});
        drain();
        issue(2'd1, 32'hDEADBEEF, 32'h1234, dummy, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_hi",   64'(hi),   64'd0);
        check("async_rst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst = 1'b0; m_hi = '0; m_lo = '0;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("rst_no_done", 64'(done_cnt), 64'(d0));

        run('{2'd3, 32'd88, 32'd8, 32'd0, 32'd11, 1'b0});
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
